quad_paddle_decoder: RTL and testbench
======================================

// Module: quad_paddle_decoder
// PURPOSE
//  Upstream feeder for the pong renderer. Turns the raw quadrature encoder pins
//  (quadA/quadB) into the 9-bit PaddlePosition the renderer draws.
//  Flow: synchronise -> glitch-filter -> decode -> saturating position counter.
//  A frame-latched copy of the position is held so the paddle never moves mid-frame.
// PARAMETERS
//  POS_W      9    position width; matches renderer PaddlePosition
//  POS_MIN    2    lower clamp of position
//  POS_MAX    508  upper clamp of position; paddle right edge POS_MAX+120 stays inside border
//  POS_RESET  264  position after reset
//  STEP       2    position change per legal quadrature edge
//  FILT_LEN   4    consecutive stable clocks before a pin change is accepted (>=1)
// PORTS
//  clk              in   1      pixel clock, same domain as hvsync_generator
//  rst_n            in   1      synchronous active-low reset
//  quad_a           in   1      encoder A, asynchronous
//  quad_b           in   1      encoder B, asynchronous
//  frame_tick       in   1      1-clk pulse once per frame (CounterY==500 & CounterX==0)
//  paddle_pos       out  POS_W  frame-latched position, to renderer
//  paddle_pos_live  out  POS_W  position updated every step
//  step_pulse       out  1      1-clk pulse per accepted legal edge
//  step_dir         out  1      direction of last step: 1=up (+STEP), 0=down
//  quad_err         out  1      1-clk pulse on illegal transition (both pins changed)
//  err_count        out  8      illegal-transition count, saturates at 255
// BEHAVIOUR
//  Reset (rst_n==0 at posedge):
//   - paddle_pos = paddle_pos_live = POS_RESET
//   - step_pulse, step_dir, quad_err, err_count = 0
//   - sync/filter state cleared; primed flag cleared
//   - Reset mid-filter discards any pending count; no step is produced.
//  Sync: each pin passes through 2 flops.
//  Filter, per pin:
//   - Counter increments while sync value != filtered value; clears when they are equal.
//   - Reaching FILT_LEN loads filtered value and clears the counter.
//   - Pulses shorter than FILT_LEN clocks are ignored.
//  Priming:
//   - First clock after reset with primed==0: filtered = sync values, prev = filtered, primed <= 1.
//   - This capture never produces a step or an error, whatever the pin levels.
//  Decode (registered, one clock after a filter update). With (A,B) new filtered, (Ap,Bp) previous:
//   - chg = (A^Ap) + (B^Bp)
//   - chg==1: legal. step_pulse=1, step_dir = A ^ Bp.
//   - chg==2: illegal. quad_err=1, err_count+1 (sat). Position and step_dir unchanged.
//   - A and B filters accepting on the same clock count as chg==2.
//  Up sequence AB: 00->10->11->01->00.
//  Position:
//   - Applied on the same edge that asserts step_pulse.
//   - up: live = min(live+STEP, POS_MAX); down: live = max(live-STEP, POS_MIN).
//   - Arithmetic runs at POS_W+1 bits so it never wraps.
//   - step_pulse still fires when clamped.
//  Latency:
//   - Pin edge to step_pulse/live update = 2 (sync) + FILT_LEN + 1 clocks, i.e. 7 at default.
//  Frame latch:
//   - On a frame_tick clock, paddle_pos <= paddle_pos_live register value at that edge.
//   - A step on that same edge lands in live only; paddle_pos picks it up at the next frame_tick.
// STRUCTURE
//  Shared include pong_defs.vh: PADDLE_W, PADDLE_MIN, PADDLE_MAX, PADDLE_RESET.
//  The renderer uses the same constants.
//  One sub-module, quad_glitch_filter (sync + stability counter, one pin), instantiated twice.
//  Top holds priming, decode, position counter, frame latch and error counter.
// TESTING (defaults)
//  1 Reset: hold A=B=1 with rst_n=0 for 3 clk, release, idle 20 clk
//    -> pos=live=264, no step_pulse, no quad_err, err_count=0.
//  2 Up sequence: AB 00->10->11->01->00, each level held 10 clk
//    -> 4 step_pulses, step_dir=1, each 7 clk after its edge, live=272.
//    -> paddle_pos stays 264 until frame_tick, then 272 on the next clock.
//  3 Glitch: A high 3 clk then low -> no step. A high 4 clk -> exactly one step.
//  4 Illegal: AB 00->11 on the same clock
//    -> quad_err one clk, err_count=1, live unchanged, step_dir unchanged.
//  5 Saturation: 130 up steps from 264 -> live reaches 508 after step 122, stays 508, 130 step_pulses.
//    Then 300 down steps -> live clamps at 2.
//  6 Races:
//    - frame_tick on the same clock as a step from 264 -> paddle_pos=264, live=266.
//    - rst_n low while the filter count is 3 -> all outputs at reset values, no step after release.

Source files
------------

// File: rtl/quad_paddle_decoder_pkg.sv
// Shared constants and position arithmetic for the quadrature paddle decoder.
// The renderer draws the paddle with the same position limits.
package quad_paddle_decoder_pkg;

  localparam int POS_W      = 9;    // renderer PaddlePosition width
  localparam int POS_MIN    = 2;    // lower clamp
  localparam int POS_MAX    = 508;  // upper clamp, right edge +120 stays inside border
  localparam int POS_RESET  = 264;  // position after reset
  localparam int STEP       = 2;    // change per legal quadrature edge
  localparam int FILT_LEN   = 4;    // stable clocks before a pin change is accepted
  localparam int FILT_CNT_W = $clog2(FILT_LEN + 1);
  localparam int ERR_W      = 8;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   pos_ext_t;

  // One saturating step; the extra bit keeps the sum from wrapping before the clamp.
  function automatic pos_t next_pos(input pos_t live, input logic up);
    pos_ext_t wide;
    if (up) begin
      wide = {1'b0, live} + pos_ext_t'(STEP);
      if (wide > pos_ext_t'(POS_MAX)) wide = pos_ext_t'(POS_MAX);
    end else begin
      if ({1'b0, live} < pos_ext_t'(POS_MIN + STEP)) wide = pos_ext_t'(POS_MIN);
      else wide = {1'b0, live} - pos_ext_t'(STEP);
    end
    return pos_t'(wide);
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder pin: two-flop synchroniser followed by a stability counter.
// A new level is accepted only after FILT_LEN consecutive clocks of disagreement
// with the current filtered level; any agreement restarts the count.
module quad_glitch_filter
  import quad_paddle_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic prime,   // load filtered level straight from the synchroniser
  input  logic enable,  // stability counting only runs once primed
  output logic synced,
  output logic filt
);

  logic                  sync_1;
  logic                  sync_2;
  logic [FILT_CNT_W-1:0] cnt;

  assign synced = sync_2;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pin;
      sync_2 <= sync_1;
    end
  end

  // Stability counter; reaching FILT_LEN accepts the synchronised level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (prime) begin
      filt <= sync_2;
      cnt  <= '0;
    end else if (enable) begin
      if (sync_2 == filt) begin
        cnt <= '0;
      end else if (cnt == FILT_CNT_W'(FILT_LEN - 1)) begin
        filt <= sync_2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_paddle_decoder.sv
// Quadrature encoder to paddle position: filtered pins are decoded one clock
// after a filter update into up/down steps or illegal-transition errors, the
// live position saturates at POS_MIN/POS_MAX, and a copy is latched per frame.
module quad_paddle_decoder
  import quad_paddle_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             frame_tick,
  output logic [POS_W-1:0] paddle_pos,
  output logic [POS_W-1:0] paddle_pos_live,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             quad_err,
  output logic [ERR_W-1:0] err_count
);

  logic       a_sync, b_sync;
  logic       a_filt, b_filt;
  logic       a_prev, b_prev;
  logic [1:0] warm;
  logic       primed;
  logic       prime;
  logic [1:0] chg;
  logic       dir_now;

  // The synchronisers are cleared by reset too, so priming waits until they
  // hold real pin samples; otherwise a pin held high through reset would look
  // like an edge right after release.
  assign prime   = !primed && (warm == 2'd2);
  assign chg     = {1'b0, a_filt ^ a_prev} + {1'b0, b_filt ^ b_prev};
  assign dir_now = a_filt ^ b_prev;

  quad_glitch_filter u_filt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin    (quad_a),
    .prime  (prime),
    .enable (primed),
    .synced (a_sync),
    .filt   (a_filt)
  );

  quad_glitch_filter u_filt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin    (quad_b),
    .prime  (prime),
    .enable (primed),
    .synced (b_sync),
    .filt   (b_filt)
  );

  // Priming sequencer: count synchroniser fill clocks, then mark primed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm   <= 2'd0;
      primed <= 1'b0;
    end else if (!primed) begin
      if (warm != 2'd2) warm <= warm + 2'd1;
      else              primed <= 1'b1;
    end
  end

  // Decode filtered pin changes into steps/errors and update the live position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_prev          <= 1'b0;
      b_prev          <= 1'b0;
      step_pulse      <= 1'b0;
      step_dir        <= 1'b0;
      quad_err        <= 1'b0;
      err_count       <= '0;
      paddle_pos_live <= pos_t'(POS_RESET);
    end else begin
      step_pulse <= 1'b0;
      quad_err   <= 1'b0;
      if (prime) begin
        a_prev <= a_sync;
        b_prev <= b_sync;
      end else if (primed) begin
        a_prev <= a_filt;
        b_prev <= b_filt;
        if (chg == 2'd1) begin
          step_pulse      <= 1'b1;
          step_dir        <= dir_now;
          paddle_pos_live <= next_pos(paddle_pos_live, dir_now);
        end else if (chg == 2'd2) begin
          quad_err <= 1'b1;
          if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
        end
      end
    end
  end

  // Frame latch: the renderer only sees position changes at frame boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n)          paddle_pos <= pos_t'(POS_RESET);
    else if (frame_tick) paddle_pos <= paddle_pos_live;
  end

endmodule

// File: tb/tb_quad_paddle_decoder.sv
// Bench for quad_paddle_decoder: a table of pin-level records with expected
// step/error counts and outputs, hand-written race sequences, saturation runs,
// and randomized moves checked against an event-level reference model.
module tb_quad_paddle_decoder;
  import quad_paddle_decoder_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             quad_a = 1'b0;
  logic             quad_b = 1'b0;
  logic             frame_tick = 1'b0;
  logic [POS_W-1:0] paddle_pos;
  logic [POS_W-1:0] paddle_pos_live;
  logic             step_pulse;
  logic             step_dir;
  logic             quad_err;
  logic [ERR_W-1:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int steps_seen = 0;
  int errs_seen = 0;
  int last_step_cyc = 0;

  typedef struct {
    logic a;
    logic b;
    int   hold;
    bit   lat;
    int   steps;
    int   errs;
    int   live;
    bit   dir;
    int   ecnt;
  } vec_t;

  vec_t       vecs[13];
  logic [1:0] up_seq[4];
  int         s0, e0, c0, idx, kind, glen, chg;
  int         ref_live, ref_pos, ref_err, exp_steps, exp_errs;
  logic       ref_a, ref_b, ref_dir, na, nb;

  quad_paddle_decoder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .quad_a          (quad_a),
    .quad_b          (quad_b),
    .frame_tick      (frame_tick),
    .paddle_pos      (paddle_pos),
    .paddle_pos_live (paddle_pos_live),
    .step_pulse      (step_pulse),
    .step_dir        (step_dir),
    .quad_err        (quad_err),
    .err_count       (err_count)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (step_pulse) begin
      steps_seen++;
      last_step_cyc = cyc;
    end
    if (quad_err) errs_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    rst_n  = 1'b0;
    quad_a = a;
    quad_b = b;
    tick(3);
    rst_n = 1'b1;
    tick(20);
  endtask

  function automatic int model_step(input int live, input logic up);
    if (up) return (live + STEP > POS_MAX) ? POS_MAX : live + STEP;
    return (live - STEP < POS_MIN) ? POS_MIN : live - STEP;
  endfunction

  initial begin
    // Records start from AB=00 right after reset: live 264, dir 0, no errors.
    vecs[0]  = '{1'b1, 1'b0, 10, 1'b1, 1, 0, 266, 1'b1, 0};
    vecs[1]  = '{1'b1, 1'b1, 10, 1'b1, 1, 0, 268, 1'b1, 0};
    vecs[2]  = '{1'b0, 1'b1, 10, 1'b1, 1, 0, 270, 1'b1, 0};
    vecs[3]  = '{1'b0, 1'b0, 10, 1'b1, 1, 0, 272, 1'b1, 0};
    vecs[4]  = '{1'b1, 1'b0,  3, 1'b0, 0, 0, 272, 1'b1, 0};
    vecs[5]  = '{1'b0, 1'b0, 10, 1'b0, 0, 0, 272, 1'b1, 0};
    vecs[6]  = '{1'b1, 1'b0,  4, 1'b0, 0, 0, 272, 1'b1, 0};
    vecs[7]  = '{1'b0, 1'b0,  4, 1'b0, 1, 0, 274, 1'b1, 0};
    vecs[8]  = '{1'b0, 1'b0, 10, 1'b0, 1, 0, 272, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b1, 10, 1'b0, 0, 1, 272, 1'b0, 1};
    vecs[10] = '{1'b0, 1'b0, 10, 1'b0, 0, 1, 272, 1'b0, 2};
    vecs[11] = '{1'b0, 1'b1, 10, 1'b1, 1, 0, 270, 1'b0, 2};
    vecs[12] = '{1'b1, 1'b1, 10, 1'b1, 1, 0, 268, 1'b0, 2};
    up_seq[0] = 2'b00;
    up_seq[1] = 2'b10;
    up_seq[2] = 2'b11;
    up_seq[3] = 2'b01;

    // Reset with both pins high, then idle
    do_reset(1'b1, 1'b1);
    check("reset pos", paddle_pos, 264);
    check("reset live", paddle_pos_live, 264);
    check("reset steps", steps_seen, 0);
    check("reset errs", errs_seen, 0);
    check("reset err_count", err_count, 0);
    check("reset step_dir", step_dir, 0);

    // Table: up sequence, glitches, illegal transitions, down steps
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      s0 = steps_seen;
      e0 = errs_seen;
      c0 = cyc;
      quad_a = vecs[i].a;
      quad_b = vecs[i].b;
      tick(vecs[i].hold);
      check($sformatf("row%0d steps", i), steps_seen - s0, vecs[i].steps);
      check($sformatf("row%0d errs", i), errs_seen - e0, vecs[i].errs);
      check($sformatf("row%0d live", i), paddle_pos_live, vecs[i].live);
      check($sformatf("row%0d dir", i), step_dir, vecs[i].dir);
      check($sformatf("row%0d err_count", i), err_count, vecs[i].ecnt);
      if (vecs[i].lat) check($sformatf("row%0d latency", i), last_step_cyc - c0, 7);
    end

    // Frame latch holds until frame_tick
    check("frame hold pos", paddle_pos, 264);
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    check("frame latched pos", paddle_pos, 268);
    tick(1);

    // frame_tick on the same edge as a step
    do_reset(1'b0, 1'b0);
    quad_a = 1'b1;
    tick(6);
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    check("race step_pulse", step_pulse, 1);
    check("race pos", paddle_pos, 264);
    check("race live", paddle_pos_live, 266);
    tick(2);
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    check("race next frame pos", paddle_pos, 266);

    // Reset while the filter count is 3
    s0 = steps_seen;
    e0 = errs_seen;
    quad_b = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(15);
    check("midrst steps", steps_seen - s0, 0);
    check("midrst errs", errs_seen - e0, 0);
    check("midrst live", paddle_pos_live, 264);
    check("midrst pos", paddle_pos, 264);
    check("midrst step_dir", step_dir, 0);
    check("midrst err_count", err_count, 0);

    // Saturation: 130 up steps then 300 down steps, starting from AB=11
    idx = 2;
    s0 = steps_seen;
    for (int i = 0; i < 130; i++) begin
      idx = (idx + 1) % 4;
      quad_a = up_seq[idx][1];
      quad_b = up_seq[idx][0];
      tick(8);
      if (i == 120) check("sat step121 live", paddle_pos_live, 506);
      if (i == 121) check("sat step122 live", paddle_pos_live, 508);
    end
    check("sat up live", paddle_pos_live, 508);
    check("sat up steps", steps_seen - s0, 130);
    check("sat up dir", step_dir, 1);
    s0 = steps_seen;
    for (int i = 0; i < 300; i++) begin
      idx = (idx + 3) % 4;
      quad_a = up_seq[idx][1];
      quad_b = up_seq[idx][0];
      tick(8);
    end
    check("sat down live", paddle_pos_live, 2);
    check("sat down steps", steps_seen - s0, 300);
    check("sat down dir", step_dir, 0);

    // Randomized moves against the event-level model
    ref_a = quad_a;
    ref_b = quad_b;
    ref_live = 2;
    ref_pos = 264;
    ref_dir = 1'b0;
    ref_err = 0;
    for (int i = 0; i < 150; i++) begin
      s0 = steps_seen;
      e0 = errs_seen;
      kind = $urandom_range(0, 3);
      case (kind)
        0: quad_a = ~ref_a;
        1: quad_b = ~ref_b;
        2: begin
          quad_a = ~ref_a;
          quad_b = ~ref_b;
        end
        default: begin
          glen = $urandom_range(1, FILT_LEN - 1);
          if ($urandom_range(0, 1) == 1) quad_a = ~ref_a;
          else quad_b = ~ref_b;
          tick(glen);
          quad_a = ref_a;
          quad_b = ref_b;
        end
      endcase
      tick($urandom_range(9, 14));
      na = quad_a;
      nb = quad_b;
      chg = int'(na ^ ref_a) + int'(nb ^ ref_b);
      exp_steps = 0;
      exp_errs = 0;
      if (chg == 1) begin
        ref_dir = na ^ ref_b;
        ref_live = model_step(ref_live, ref_dir);
        exp_steps = 1;
      end else if (chg == 2) begin
        exp_errs = 1;
        if (ref_err < 255) ref_err++;
      end
      ref_a = na;
      ref_b = nb;
      if ($urandom_range(0, 3) == 0) begin
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        ref_pos = ref_live;
      end
      check($sformatf("rnd%0d steps", i), steps_seen - s0, exp_steps);
      check($sformatf("rnd%0d errs", i), errs_seen - e0, exp_errs);
      check($sformatf("rnd%0d live", i), paddle_pos_live, ref_live);
      check($sformatf("rnd%0d pos", i), paddle_pos, ref_pos);
      check($sformatf("rnd%0d dir", i), step_dir, ref_dir);
      check($sformatf("rnd%0d err_count", i), err_count, ref_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
